// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator: reset vector,
// next-PC source encoding and the target alignment mask helper.
package pc_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_2000;
  localparam int unsigned MAX_XLEN = 64;

  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_PEND_TRAP,
    SRC_REDIR,
    SRC_PEND_REDIR,
    SRC_RAS,
    SRC_SEQ
  } next_src_e;

  // All-ones mask with the low align_bits cleared; callers truncate to XLEN.
  function automatic logic [MAX_XLEN-1:0] align_mask(input int unsigned align_bits);
    return {MAX_XLEN{1'b1}} << align_bits;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; pushing when full silently drops the oldest entry.
module return_address_stack #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             replace_top;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign top         = mem[top_ptr];
  assign replace_top = push && pop && !empty;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = top_ptr;
    if (!flush && push) begin
      wr_en  = 1'b1;
      wr_idx = replace_top ? top_ptr : top_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= push_addr;
  end

  // Push+pop on a non-empty stack just swaps the top entry in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (replace_top) begin
      count <= count;
    end else if (push) begin
      top_ptr <= top_ptr + PTR_W'(1);
      if (!full)
        count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: arbitrates trap, redirect, RAS and sequential
// next-PC sources and holds one redirect that arrives while fetch is stalled.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic            redirect_pending,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(ALIGN_BITS));

  next_src_e       next_src;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            pend_valid;
  logic            pend_is_trap;
  logic [XLEN-1:0] pend_target;
  logic            ras_enable;
  logic            ras_do_push;
  logic            ras_do_pop;
  logic            ras_flush;

  assign redirect_pending = pend_valid;

  always_comb begin
    next_src = SRC_SEQ;
    if (trap_valid)
      next_src = SRC_TRAP;
    else if (pend_valid && pend_is_trap)
      next_src = SRC_PEND_TRAP;
    else if (redirect_valid)
      next_src = SRC_REDIR;
    else if (pend_valid)
      next_src = SRC_PEND_REDIR;
    else if (ras_pop && !ras_empty)
      next_src = SRC_RAS;
  end

  always_comb begin
    next_pc = pc + XLEN'(INC);
    case (next_src)
      SRC_TRAP:                     next_pc = trap_target & MASK;
      SRC_REDIR:                    next_pc = redirect_target & MASK;
      SRC_PEND_TRAP, SRC_PEND_REDIR: next_pc = pend_target;
      SRC_RAS:                      next_pc = ras_top & MASK;
      default:                      next_pc = pc + XLEN'(INC);
    endcase
  end

  // The RAS only moves on unstalled cycles that fall through to RAS/sequential.
  assign ras_enable  = !stall && (next_src == SRC_RAS || next_src == SRC_SEQ);
  assign ras_do_push = ras_enable && ras_push;
  assign ras_do_pop  = ras_enable && ras_pop;
  assign ras_flush   = !stall && (next_src == SRC_TRAP || next_src == SRC_PEND_TRAP);

  return_address_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_do_push),
    .pop       (ras_do_pop),
    .flush     (ras_flush),
    .push_addr (ras_push_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pc <= RESET_VECTOR;
    else if (!stall)
      pc <= next_pc;
  end

  // A held trap is never displaced by a redirect; same-or-higher priority replaces.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid   <= 1'b0;
      pend_is_trap <= 1'b0;
      pend_target  <= '0;
    end else if (stall) begin
      if (trap_valid) begin
        pend_valid   <= 1'b1;
        pend_is_trap <= 1'b1;
        pend_target  <= trap_target & MASK;
      end else if (redirect_valid && !(pend_valid && pend_is_trap)) begin
        pend_valid   <= 1'b1;
        pend_is_trap <= 1'b0;
        pend_target  <= redirect_target & MASK;
      end
    end else begin
      pend_valid   <= 1'b0;
      pend_is_trap <= 1'b0;
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the RISC-V fetch stage. It replaces the single-source program counter with a block that arbitrates four next-PC sources:
- trap vector;
- execute-stage redirect (branch/jump);
- return-address-stack (RAS) prediction;
- sequential increment.

Redirects that arrive while fetch is stalled are held and applied once fetch resumes. Sits between the instruction memory address port and the execute/CSR stages.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 32'h0000_2000, PC value loaded by reset
- INC, 4, sequential increment in bytes
- ALIGN_BITS, 2, low target bits forced to zero (1 when compressed instructions are enabled)
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC; no state other than the pending register changes
- trap_valid  in  1  trap/exception redirect request
- trap_target  in  XLEN  trap handler address
- redirect_valid  in  1  execute-stage branch/jump redirect
- redirect_target  in  XLEN  redirect address
- ras_push  in  1  fetched instruction is a call
- ras_push_addr  in  XLEN  return address to push
- ras_pop  in  1  fetched instruction is a return; predict from RAS top
- pc  out  XLEN  current fetch address (registered)
- redirect_pending  out  1  a held redirect is waiting for stall release
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH

## Operation
- Reset (reset_n low, asynchronous):
  - pc = RESET_VECTOR;
  - pending register cleared (redirect_pending = 0);
  - RAS count = 0 (ras_empty = 1, ras_full = 0).
- Unstalled cycle, next pc priority:
  1. live trap;
  2. pending trap;
  3. live redirect;
  4. pending redirect;
  5. RAS top (ras_pop && !ras_empty);
  6. pc + INC.
- All target sources have their low ALIGN_BITS bits cleared. Arithmetic wraps modulo 2^XLEN.
- Pending register: one {valid, is_trap, target} entry. Rules:
  - Written only on a stalled cycle with trap_valid or redirect_valid.
  - Trap beats redirect when both arrive in the same cycle.
  - A pending trap is not overwritten by a later redirect.
  - A newer request of equal or higher priority overwrites the entry.
  - Cleared on the first unstalled cycle, whichever source wins.
- RAS (circular buffer of RAS_DEPTH entries):
  - Push: write ras_push_addr at top+1; count saturates at RAS_DEPTH. Pushing when full overwrites the oldest entry.
  - Pop when not empty: next pc = top; count decrements.
  - Pop when empty: ignored; next pc is sequential.
  - Push and pop together: next pc = old top; top entry replaced by ras_push_addr; count unchanged. If empty, this is treated as a plain push.
  - Trap applied (live or pending): RAS count cleared.
  - Push/pop are ignored on any cycle where a trap or redirect is applied, and on any stalled cycle.

## Timing
- Next-PC latency is one cycle: a source sampled at edge N is visible on pc after edge N.
- Stalled cycle: pc and RAS hold. Only the pending register may change.
- Redirect during stall: applied on the first edge with stall low. redirect_pending drops on that same edge.
- Reset mid-stall or with a request pending: everything returns to reset values immediately; the pending request is discarded.
- Reset release: the first edge with reset_n high and stall low loads pc = RESET_VECTOR + INC, unless a request is present.

## Structure
- Package pc_pkg:
  - DEFAULT_RESET_VECTOR;
  - next-PC source enum (SRC_TRAP, SRC_PEND_TRAP, SRC_REDIR, SRC_PEND_REDIR, SRC_RAS, SRC_SEQ), also exported for debug and coverage;
  - an alignment-mask helper function.
- Sub-module return_address_stack (DEPTH, XLEN parameters; push/pop/flush in; top, empty and full out).
- pc_gen holds the arbitration, the pending register and the pc register.

## Test plan
- Reset, then free-run 3 cycles -> pc = 0x2000, 0x2004, 0x2008, 0x200C.
- redirect_valid with target 0x3003, unstalled -> next pc = 0x3000; with ALIGN_BITS = 1 -> 0x3002.
- stall high; redirect to 0x4000 in cycle 1, trap to 0x100 in cycle 2, redirect to 0x5000 in cycle 3; then stall low:
  - redirect_pending = 1 during the stall;
  - pc = 0x100 one cycle after release;
  - redirect_pending = 0.
- RAS sequence: push 0x1010, push 0x2020, pop, pop, pop -> pc after the pops = 0x2020, 0x1010, then sequential; ras_empty = 1 at the end.
- RAS_DEPTH = 4: push 5 addresses A..E, then pop 5 times:
  - pops return E, D, C, B;
  - the fifth pop is sequential;
  - ras_full = 1 after the 4th push.
- Trap concurrent with ras_pop and a live redirect to 0x8000 -> pc = trap_target, RAS flushed (ras_empty = 1). Assert reset_n low mid-stall with a request pending -> pc = 0x2000 asynchronously and redirect_pending = 0.
